kbd_rx_buffer: RTL

KBD_RX_BUFFER -- requirements
Module: kbd_rx_buffer

---
 rtl/kbd_rx_buffer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/kbd_rx_buffer.sv
// kbd_rx_buffer: receives ASCII bytes from a keyboard driver over a 4-phase
// req/ack handshake and queues them in a FIFO that the CPU pops. A level
// interrupt is raised while bytes are waiting and the CPU has it enabled.
module kbd_rx_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          kbd_int_req,
  input  logic [7:0]    kbd_data,
  output logic          kbd_int_ack,
  input  logic          rd_en,
  input  logic          flush,
  input  logic          int_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          cpu_int
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_ACK   = 1'b1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic          req_meta_r;
  logic          req_s;
  logic [0:0]    state_r;
  logic          ack_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          empty_r;
  logic          full_r;
  logic [7:0]    rd_data_r;

  logic          do_write_s;
  logic          do_pop_s;
  logic [AW:0]   count_next_s;
  logic [7:0]    rd_data_next_s;

  // Capture and pop qualification, next occupancy and next head byte.
  always_comb begin
    do_write_s     = (state_r == ST_IDLE) && req_s && !full_r && !flush;
    do_pop_s       = rd_en && !empty_r && !flush;
    count_next_s   = count_r;
    rd_data_next_s = rd_data_r;
    if (flush) begin
      count_next_s = '0;
    end else if (do_write_s && !do_pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (do_pop_s && !do_write_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
    // Head byte: next stored entry on a pop, the incoming byte when it
    // becomes the head, otherwise hold (keeps the last popped byte).
    if (flush) begin
      rd_data_next_s = rd_data_r;
    end else if (do_pop_s) begin
      if (count_r > CNT_ONE) begin
        rd_data_next_s = mem[rd_ptr_r + PTR_ONE];
      end else if (do_write_s) begin
        rd_data_next_s = kbd_data;
      end else begin
        rd_data_next_s = rd_data_r;
      end
    end else if (do_write_s && empty_r) begin
      rd_data_next_s = kbd_data;
    end else begin
      rd_data_next_s = rd_data_r;
    end
  end

  // Two-flop synchronizer for the asynchronous keyboard request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta_r <= 1'b0;
      req_s      <= 1'b0;
    end else begin
      req_meta_r <= kbd_int_req;
      req_s      <= req_meta_r;
    end
  end

  // Handshake FSM: acknowledge on capture, release once the request drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ack_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (do_write_s) begin
            state_r <= ST_ACK;
            ack_r   <= 1'b1;
          end
        end
        ST_ACK: begin
          if (!req_s) begin
            state_r <= ST_IDLE;
            ack_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ack_r   <= 1'b0;
        end
      endcase
    end
  end

  // Pointers, occupancy, flags and head byte; flush wins over write/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      empty_r   <= 1'b1;
      full_r    <= 1'b0;
      rd_data_r <= 8'h00;
    end else begin
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (do_write_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (do_pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
      end
      count_r   <= count_next_s;
      empty_r   <= (count_next_s == '0);
      full_r    <= (count_next_s == CNT_FULL);
      rd_data_r <= rd_data_next_s;
    end
  end

  // FIFO storage; contents are not reset, only pointers and flags are.
  always_ff @(posedge clk) begin
    if (do_write_s) begin
      mem[wr_ptr_r] <= kbd_data;
    end
  end

  assign kbd_int_ack = ack_r;
  assign rd_data     = rd_data_r;
  assign empty       = empty_r;
  assign full        = full_r;
  assign count       = count_r;
  assign cpu_int     = int_en & ~empty_r;

endmodule
